// File: rtl/ysyx_23060278_seq_ctrl.sv
// Multi-cycle fetch/execute/load-store/writeback sequencer for the single-issue RV32 core.
// All outputs are registered; every request is held until its ready, and each wait state has a timeout.
module ysyx_23060278_seq_ctrl #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic             ifu_rsp_err,
  input  logic [31:0]      ifu_rsp_inst,
  output logic [31:0]      inst_q,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_wb,
  input  logic             dec_ebreak,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  input  logic             lsu_rsp_err,
  output logic             pc_wen,
  output logic             gpr_wen,
  output logic             halt,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int unsigned WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_IF_REQ,
    S_IF_WAIT,
    S_EX,
    S_LS_REQ,
    S_LS_WAIT,
    S_WB,
    S_HALT,
    S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]       inst_d;
  logic              timed_out;
  logic              waiting;
  logic              ifu_req_valid_d, lsu_req_valid_d;
  logic              pc_wen_d, gpr_wen_d, halt_d, fault_d;
  logic [CNT_W-1:0]  cycle_cnt_d, instret_cnt_d;

  // The counter sits one below TIMEOUT in the last permitted cycle; an exit event in that cycle still wins.
  assign timed_out = (wait_cnt_q == WC_LAST);
  assign waiting   = (state_q == S_IF_REQ) || (state_q == S_IF_WAIT) ||
                     (state_q == S_LS_REQ) || (state_q == S_LS_WAIT);

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    unique case (state_q)
      S_IDLE:    state_d = S_IF_REQ;
      S_IF_REQ: begin
        if (ifu_req_valid && ifu_req_ready) state_d = S_IF_WAIT;
        else if (timed_out)                 state_d = S_FAULT;
      end
      S_IF_WAIT: begin
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            state_d = S_FAULT;
          end else begin
            inst_d  = ifu_rsp_inst;
            state_d = S_EX;
          end
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end
      S_EX: begin
        if (dec_ebreak)               state_d = S_HALT;
        else if (dec_load || dec_store) state_d = S_LS_REQ;
        else                          state_d = S_WB;
      end
      S_LS_REQ: begin
        if (lsu_req_valid && lsu_req_ready) state_d = S_LS_WAIT;
        else if (timed_out)                 state_d = S_FAULT;
      end
      S_LS_WAIT: begin
        if (lsu_rsp_valid) state_d = lsu_rsp_err ? S_FAULT : S_WB;
        else if (timed_out) state_d = S_FAULT;
      end
      S_WB:      state_d = S_IF_REQ;
      S_HALT:    state_d = S_HALT;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d = '0;
    if (state_d == state_q && waiting) wait_cnt_d = wait_cnt_q + WC_W'(1);
  end

  // Outputs are decoded from the next state so they are flops aligned with the state they describe.
  always_comb begin
    ifu_req_valid_d = (state_d == S_IF_REQ);
    lsu_req_valid_d = (state_d == S_LS_REQ);
    pc_wen_d        = (state_d == S_WB);
    gpr_wen_d       = (state_d == S_WB) && dec_wb && !dec_store;
    halt_d          = (state_d == S_HALT) || (state_d == S_FAULT);
    fault_d         = (state_d == S_FAULT);
    cycle_cnt_d     = halt ? cycle_cnt : cycle_cnt + CNT_W'(1);
    instret_cnt_d   = (state_q == S_WB) ? instret_cnt + CNT_W'(1) : instret_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      inst_q        <= '0;
      ifu_req_valid <= 1'b0;
      lsu_req_valid <= 1'b0;
      pc_wen        <= 1'b0;
      gpr_wen       <= 1'b0;
      halt          <= 1'b0;
      fault         <= 1'b0;
      cycle_cnt     <= '0;
      instret_cnt   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      inst_q        <= inst_d;
      ifu_req_valid <= ifu_req_valid_d;
      lsu_req_valid <= lsu_req_valid_d;
      pc_wen        <= pc_wen_d;
      gpr_wen       <= gpr_wen_d;
      halt          <= halt_d;
      fault         <= fault_d;
      cycle_cnt     <= cycle_cnt_d;
      instret_cnt   <= instret_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060278_seq_ctrl.sv
// Scoreboard bench for the sequencer: behavioural imem/LSU responders, retire monitor, directed phases.
module tb_ysyx_23060278_seq_ctrl;
  localparam int TMO = 8;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] ADDI1  = 32'h00100093;
  localparam logic [31:0] ADDI2  = 32'h00208113;
  localparam logic [31:0] ADDI3  = 32'h00310193;
  localparam logic [31:0] LW1    = 32'h0000a203;
  localparam logic [31:0] LW2    = 32'h0040a283;
  localparam logic [31:0] SW1    = 32'h0040a023;
  localparam logic [31:0] BEQ1   = 32'h00000063;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready = 1'b0;
  logic        ifu_rsp_valid = 1'b0, ifu_rsp_err = 1'b0;
  logic [31:0] ifu_rsp_inst = '0;
  logic [31:0] inst_q;
  logic        dec_load, dec_store, dec_wb, dec_ebreak;
  logic        lsu_req_valid, lsu_req_ready = 1'b0;
  logic        lsu_rsp_valid = 1'b0, lsu_rsp_err = 1'b0;
  logic        pc_wen, gpr_wen, halt, fault;
  logic [31:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  ysyx_23060278_seq_ctrl #(.TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .ifu_rsp_inst(ifu_rsp_inst),
    .inst_q(inst_q),
    .dec_load(dec_load), .dec_store(dec_store), .dec_wb(dec_wb), .dec_ebreak(dec_ebreak),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
    .pc_wen(pc_wen), .gpr_wen(gpr_wen), .halt(halt), .fault(fault),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  // Minimal decoder standing in for the IDU.
  assign dec_load   = (inst_q[6:0] == 7'b0000011);
  assign dec_store  = (inst_q[6:0] == 7'b0100011);
  assign dec_ebreak = (inst_q == EBREAK);
  assign dec_wb     = (inst_q[6:0] != 7'b1100011);

  typedef struct { logic [31:0] inst; int stall; bit ierr; bit lerr; } prog_t;
  typedef struct { logic [31:0] inst; bit gw; bit ls; int lat; } exp_t;

  prog_t prog_q[$];
  exp_t  sb_q[$];
  prog_t p;
  exp_t  e;
  int total = 0, bad = 0;
  int cyc = 0, edges = 0;
  int imem_dly = 0;
  bit imem_mute = 0, lsu_mute = 0;
  int if_pend = 0, if_hs_cyc = 0;
  bit ls_pend = 0, ls_hs_seen = 0, cur_lerr = 0;
  int cur_stall = 0, cur_stall0 = 0, ls_vcnt = 0, ls_rsp_cyc = 0;
  int last_pc = -1, exp_ret = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #2;
  endtask

  function automatic void push(input logic [31:0] inst, input int stall = 0,
                               input bit ierr = 0, input bit lerr = 0);
    prog_t t;
    t.inst = inst; t.stall = stall; t.ierr = ierr; t.lerr = lerr;
    prog_q.push_back(t);
  endfunction

  always @(posedge clk) begin
    if (rst) edges = 0;
    else     edges++;
  end

  // Responders and retire monitor; everything is driven and sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if_pend = 0; ls_pend = 0; ls_vcnt = 0; last_pc = -1;
      ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0;
      lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0;
    end else begin
      if (pc_wen) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          chk("ret_inst", inst_q, e.inst);
          chk("ret_gpr_wen", gpr_wen, e.gw);
          chk("ret_instret", instret_cnt, exp_ret);
          chk("ret_halt", halt, 1'b0);
          if (e.ls) chk("ls_rsp_to_wb", cyc - ls_rsp_cyc, 1);
          if (last_pc >= 0) chk("ret_interval", cyc - last_pc, e.lat);
          last_pc = cyc;
          exp_ret++;
        end
      end else if (gpr_wen) begin
        chk("gpr_wen_without_pc_wen", gpr_wen, 1'b0);
      end

      ifu_rsp_valid = 0; ifu_rsp_err = 0; ifu_rsp_inst = $urandom;
      if (if_pend > 0) begin
        if_pend--;
        if (if_pend == 0) begin
          if (prog_q.size() > 0) p = prog_q.pop_front();
          else begin p.inst = EBREAK; p.stall = 0; p.ierr = 0; p.lerr = 0; end
          ifu_rsp_valid = 1; ifu_rsp_err = p.ierr; ifu_rsp_inst = p.inst;
          if (!p.ierr) begin
            cur_stall = p.stall; cur_stall0 = p.stall; cur_lerr = p.lerr;
            if (p.inst != EBREAK && !p.lerr) begin
              e.inst = p.inst;
              e.ls   = (p.inst[6:0] == 7'b0000011) || (p.inst[6:0] == 7'b0100011);
              e.gw   = (p.inst[6:0] != 7'b0100011) && (p.inst[6:0] != 7'b1100011);
              e.lat  = 4 + imem_dly + (e.ls ? 2 + p.stall : 0);
              sb_q.push_back(e);
            end
          end
        end
      end
      ifu_req_ready = 1;
      if (ifu_req_valid) begin
        if_hs_cyc = cyc;
        if (!imem_mute) if_pend = imem_dly + 1;
      end

      lsu_rsp_valid = 0; lsu_rsp_err = 0;
      if (ls_pend) begin
        ls_pend = 0; lsu_rsp_valid = 1; lsu_rsp_err = cur_lerr; ls_rsp_cyc = cyc;
      end
      lsu_req_ready = 0;
      if (lsu_req_valid) begin
        ls_vcnt++;
        if (cur_stall > 0) begin
          cur_stall--;
        end else begin
          lsu_req_ready = 1;
          chk("lsu_vld_hold", ls_vcnt, cur_stall0 + 1);
          ls_vcnt = 0; ls_hs_seen = 1;
          ls_pend = !lsu_mute;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1;
    sb_q.delete(); prog_q.delete(); exp_ret = 0; ls_hs_seen = 0;
    tick(2);
    chk("rst_ctl", {ifu_req_valid, lsu_req_valid, pc_wen, gpr_wen, halt, fault}, 6'b0);
    chk("rst_inst", inst_q, 32'h0);
    chk("rst_cycle", cycle_cnt, 32'h0);
    chk("rst_instret", instret_cnt, 32'h0);
    rst = 0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halt && n < budget) begin tick(); n++; end
    chk("halt_seen", halt, 1'b1);
  endtask

  initial begin
    int c;
    // ALU stream, loads (one with a stalled LSU), store with dec_wb, branch, ebreak.
    do_reset();
    push(ADDI1); push(ADDI2); push(ADDI3);
    push(LW1); push(LW2, 5); push(SW1); push(BEQ1); push(EBREAK);
    wait_halt(300);
    chk("a_cycle_at_halt", cycle_cnt, edges);
    chk("a_fault", fault, 1'b0);
    chk("a_instret", instret_cnt, 32'd7);
    chk("a_inst_q", inst_q, EBREAK);
    chk("a_sb_left", 64'(sb_q.size()), 64'd0);
    c = edges;
    tick(5);
    chk("a_cycle_frozen", cycle_cnt, c);
    chk("a_halt_sticky", {halt, pc_wen, ifu_req_valid}, 3'b100);

    // Instruction memory never answers: fault after exactly TMO cycles in IF_WAIT.
    do_reset();
    imem_mute = 1;
    c = 0;
    while (!fault && c < 60) begin tick(); c++; end
    chk("b_fault", fault, 1'b1);
    chk("b_tmo_cycles", cyc - if_hs_cyc, TMO + 1);
    chk("b_halt", halt, 1'b1);
    chk("b_cycle_at_fault", cycle_cnt, edges);
    imem_mute = 0;

    // Response on the last permitted cycle beats the timeout.
    do_reset();
    imem_dly = TMO - 1;
    push(ADDI1); push(EBREAK);
    wait_halt(100);
    chk("b2_fault", fault, 1'b0);
    chk("b2_instret", instret_cnt, 32'd1);
    imem_dly = 0;

    // Fetch bus error: fault, nothing latched.
    do_reset();
    push(ADDI1, 0, 1);
    wait_halt(50);
    chk("c_fault", fault, 1'b1);
    chk("c_inst_q", inst_q, 32'h0);
    chk("c_instret", instret_cnt, 32'd0);

    // LSU bus error: fault, instruction kept in inst_q.
    do_reset();
    push(ADDI2); push(LW1, 0, 0, 1);
    wait_halt(50);
    chk("c2_fault", fault, 1'b1);
    chk("c2_inst_q", inst_q, LW1);
    chk("c2_instret", instret_cnt, 32'd1);

    // Reset while parked in LS_WAIT, then restart cleanly.
    do_reset();
    lsu_mute = 1;
    push(LW2);
    c = 0;
    while (!ls_hs_seen && c < 40) begin tick(); c++; end
    chk("d_ls_accepted", ls_hs_seen, 1'b1);
    tick(2);
    rst = 1;
    tick(1);
    chk("d_rst_ctl", {ifu_req_valid, lsu_req_valid, pc_wen, gpr_wen, halt, fault}, 6'b0);
    chk("d_rst_inst", inst_q, 32'h0);
    chk("d_rst_cnt", {cycle_cnt, instret_cnt}, 64'h0);
    sb_q.delete(); prog_q.delete(); exp_ret = 0;
    lsu_mute = 0;
    push(ADDI3); push(EBREAK);
    rst = 0;
    wait_halt(60);
    chk("d_fault", fault, 1'b0);
    chk("d_instret", instret_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
